mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage pipelined CPU.
- Arbitrates requests with data priority and a starvation guard for fetch.
- Sequences each transaction over a variable-latency memory handshake and bounds it with a timeout.
- Drives per-stage stall signals that the pipeline uses to freeze its IF/ID and EX/MEM/WB registers.

Parameters:
- ADDR_W, 64, address width for both requesters and the memory port.
- MAX_D_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced.
- TIMEOUT, 16, cycles a transaction may wait for m_ready before it is aborted.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- if_req  input  1  fetch request; level, held until if_done
- if_addr  input  ADDR_W  fetch address; stable while if_req is high
- if_done  output  1  one-cycle completion pulse
- if_rdata  output  32  instruction word; valid when if_done is high
- d_req  input  1  data request; level, held until d_done
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  64  store data
- d_size  input  4  transfer size in bytes (1, 2, 4 or 8)
- d_done  output  1  one-cycle completion pulse
- d_rdata  output  64  load data; valid when d_done is high
- bus_err  output  1  pulses together with a done pulse when that transaction timed out
- m_req  output  1  memory request, registered
- m_we  output  1  memory write enable
- m_addr  output  ADDR_W  memory address
- m_wdata  output  64  memory write data
- m_size  output  4  memory transfer size
- m_rdata  input  64  memory read data; valid when m_ready is high
- m_ready  input  1  memory completion, one cycle
- stall_if  output  1  if_req & ~if_done
- stall_mem  output  1  d_req & ~d_done

Behaviour:
- Clocking: single clock clk; reset is synchronous and active-high.
- Reset, and reset asserted mid-transaction: FSM goes to IDLE at that edge. All registered outputs become 0 (m_req, m_we, m_addr, m_wdata, m_size, if_done, d_done, if_rdata, d_rdata, bus_err). Streak and timeout counters clear. An in-flight memory access is abandoned and no done pulse is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE arbitration:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both pending -> BUSY_D, unless streak == MAX_D_STREAK, in which case -> BUSY_I.
  - Neither -> stay in IDLE.
- Operand latching: on the IDLE->BUSY edge the grantee's operands are latched into m_*, and m_req = 1.
  - Fetch: m_we = 0, m_size = 4, m_wdata = 0.
- BUSY_x:
  - m_req and m_* are held stable.
  - The timeout counter increments each cycle.
  - If m_ready = 1 -> DONE_x. Read data is latched: if_rdata = m_rdata[31:0], or d_rdata = m_rdata. m_req drops at that edge.
  - If the counter reaches TIMEOUT-1 with no m_ready -> DONE_x with rdata = 0, bus_err = 1, m_req drops.
- DONE_x: the matching done pulse is high for exactly this cycle. bus_err pulses in the same cycle if the transaction timed out. Next state is always IDLE.
- DONE_x -> IDLE rule: the requester must drop req or present a new request by the cycle after done. The arbiter never re-samples req during DONE_x.
- Latency: req seen in IDLE at cycle 0 -> m_req = 1 at cycle 1 -> m_ready earliest at cycle 1 -> done at cycle 2 -> IDLE at cycle 3. Minimum throughput is one transaction per 3 cycles.
- Streak counter (saturating, 0..MAX_D_STREAK):
  - +1 on each data grant made while if_req = 1.
  - Clears on a fetch grant, and on a data grant made with if_req = 0.
- m_ready outside BUSY_x is ignored.
- d_we = 1: d_rdata is 0 at d_done.
- stall_if / stall_mem are combinational from req and registered done. They are low in the done cycle so the pipeline advances exactly once.

Decomposition:
- Package mem_arb_pkg contains:
  - the state enum (ST_IDLE, ST_BUSY_I, ST_BUSY_D, ST_DONE_I, ST_DONE_D);
  - constant IF_XFER_SIZE = 4.
- One sub-module, arb_sat_counter: a parameterised-width saturating up-counter with sync clear. It is instantiated twice, once for the streak counter and once for the timeout counter.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x40; memory returns m_ready in cycle 1 with m_rdata = 0xDEADBEEF_91000020 -> m_addr = 0x40, m_we = 0, m_size = 4 at cycle 1; if_done = 1 and if_rdata = 0x91000020 at cycle 2; stall_if = 1 in cycles 0-1 and 0 in cycle 2.
- Simultaneous requests: if_req and d_req (store, addr 0x100, wdata 0x1234, size 8) both rise in cycle 0 -> data granted first: m_we = 1, m_addr = 0x100. d_done at cycle 2; fetch granted in the following IDLE; if_done at cycle 5.
- Starvation: if_req held high while d_req issues 6 back-to-back loads -> after 4 data grants the 5th grant goes to fetch, then data resumes; streak is 0 after the fetch grant.
- Slow memory: d_req load with m_ready delayed 5 cycles -> m_req and m_addr stay stable for 5 cycles, and d_done occurs exactly 1 cycle after m_ready with d_rdata = m_rdata.
- Timeout: m_ready never asserted -> m_req drops after 16 BUSY cycles; d_done = 1, bus_err = 1, d_rdata = 0 in the same cycle; FSM returns to IDLE.
- Reset mid-operation: reset = 1 during BUSY_D (cycle 3) -> at the next edge m_req = 0, no d_done, all outputs 0, FSM in IDLE; a fresh request after reset completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D,
        ST_DONE_I,
        ST_DONE_D
    } arb_state_e;

    localparam logic [3:0] IF_XFER_SIZE = 4'd4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the arbiter, grouped in one bundle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic [3:0]        d_size;
    logic              d_done;
    logic [63:0]       d_rdata;

    logic              bus_err;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_wdata;
    logic [3:0]        m_size;
    logic [63:0]       m_rdata;
    logic              m_ready;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, m_rdata, m_ready,
        output if_done, if_rdata, d_done, d_rdata, bus_err,
               m_req, m_we, m_addr, m_wdata, m_size, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, m_rdata, m_ready,
        input  if_done, if_rdata, d_done, d_rdata, bus_err,
               m_req, m_we, m_addr, m_wdata, m_size, stall_if, stall_mem
    );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
    parameter int          W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access:
// data has priority, fetch is forced after MAX_D_STREAK data grants, each access is timeout-bounded.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic              m_req_q, m_we_q, if_done_q, d_done_q, bus_err_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [63:0]       m_wdata_q, d_rdata_q;
    logic [3:0]        m_size_q;
    logic [31:0]       if_rdata_q;

    logic [STREAK_W-1:0] streak;
    logic [TO_W-1:0]     to_cnt;
    logic idle, busy, fetch_forced, grant_d, grant_i;
    logic streak_clr, streak_inc, to_clr;

    always_comb begin
        idle         = (state_q == ST_IDLE);
        busy         = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
        fetch_forced = bus.if_req && (streak == STREAK_MAX);
        grant_d      = idle && bus.d_req && !fetch_forced;
        grant_i      = idle && bus.if_req && !grant_d;
        // The streak only grows while fetch is actually waiting on a data grant.
        streak_inc   = grant_d && bus.if_req;
        streak_clr   = reset || grant_i || (grant_d && !bus.if_req);
        to_clr       = reset || !busy;
    end

    arb_sat_counter #(.W(STREAK_W), .MAX(STREAK_MAX)) u_streak (
        .clk   (clk),
        .clr_i (streak_clr),
        .inc_i (streak_inc),
        .cnt_o (streak)
    );

    arb_sat_counter #(.W(TO_W), .MAX(TO_LAST)) u_timeout (
        .clk   (clk),
        .clr_i (to_clr),
        .inc_i (busy),
        .cnt_o (to_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_size_q   <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        state_q   <= ST_BUSY_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_size_q  <= bus.d_size;
                    end else if (grant_i) begin
                        state_q   <= ST_BUSY_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        m_wdata_q <= '0;
                        m_size_q  <= IF_XFER_SIZE;
                    end
                end
                ST_BUSY_I: begin
                    if (bus.m_ready) begin
                        state_q    <= ST_DONE_I;
                        m_req_q    <= 1'b0;
                        if_done_q  <= 1'b1;
                        if_rdata_q <= bus.m_rdata[31:0];
                    end else if (to_cnt == TO_LAST) begin
                        state_q    <= ST_DONE_I;
                        m_req_q    <= 1'b0;
                        if_done_q  <= 1'b1;
                        if_rdata_q <= '0;
                        bus_err_q  <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (bus.m_ready) begin
                        state_q   <= ST_DONE_D;
                        m_req_q   <= 1'b0;
                        d_done_q  <= 1'b1;
                        d_rdata_q <= m_we_q ? 64'd0 : bus.m_rdata;
                    end else if (to_cnt == TO_LAST) begin
                        state_q   <= ST_DONE_D;
                        m_req_q   <= 1'b0;
                        d_done_q  <= 1'b1;
                        d_rdata_q <= '0;
                        bus_err_q <= 1'b1;
                    end
                end
                ST_DONE_I, ST_DONE_D: begin
                    state_q   <= ST_IDLE;
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    bus_err_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_size    = m_size_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.bus_err   = bus_err_q;
    // Low in the done cycle so the pipeline advances exactly once per transaction.
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_mem = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random transactions against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 64;
    localparam int MAX_D_STREAK = 4;
    localparam int TIMEOUT      = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int streak      = 0;   // consecutive data grants made while fetch was waiting

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_d(input bit store);
        logic [3:0] sizes [4];
        sizes = '{4'd1, 4'd2, 4'd4, 4'd8};
        bus.d_we    = store;
        bus.d_addr  = {$urandom, $urandom};
        bus.d_wdata = {$urandom, $urandom};
        bus.d_size  = sizes[$urandom_range(3)];
    endtask

    task automatic new_i();
        bus.if_addr = {$urandom, $urandom} & ~64'd3;
    endtask

    task automatic idle_cycle();
        bus.m_ready = 1'($urandom_range(1));
        @(negedge clk);
        chk("idle_mreq", 64'(bus.m_req), 64'd0);
        chk("idle_done", 64'(bus.if_done | bus.d_done), 64'd0);
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
    endtask

    // Entered at the start of an IDLE cycle with the requests already driven;
    // returns at the start of the following IDLE cycle.
    task automatic round(input int lat, input logic [63:0] rd, output bit won_d);
        bit          gd, to;
        logic [63:0] e_addr, e_wdata;
        logic        e_we;
        logic [3:0]  e_size;
        gd = bus.d_req && !(bus.if_req && streak == MAX_D_STREAK);
        if (gd) begin
            streak  = bus.if_req ? streak + 1 : 0;
            e_addr  = bus.d_addr;  e_we = bus.d_we;
            e_wdata = bus.d_wdata; e_size = bus.d_size;
        end else begin
            streak  = 0;
            e_addr  = bus.if_addr; e_we = 1'b0;
            e_wdata = 64'd0;       e_size = 4'd4;
        end
        to = (lat > TIMEOUT - 1);

        bus.m_ready = 1'($urandom_range(1));
        bus.m_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("idle_mreq", 64'(bus.m_req), 64'd0);
        chk("idle_stall_if", 64'(bus.stall_if), 64'(bus.if_req));
        chk("idle_stall_mem", 64'(bus.stall_mem), 64'(bus.d_req));
        @(posedge clk); #1;

        for (int c = 0; c < TIMEOUT; c++) begin
            bus.m_ready = (c == lat);
            bus.m_rdata = (c == lat) ? rd : {$urandom, $urandom};
            @(negedge clk);
            chk("busy_mreq", 64'(bus.m_req), 64'd1);
            chk("busy_maddr", bus.m_addr, e_addr);
            chk("busy_mwe", 64'(bus.m_we), 64'(e_we));
            chk("busy_msize", 64'(bus.m_size), 64'(e_size));
            chk("busy_mwdata", bus.m_wdata, e_wdata);
            chk("busy_done", 64'(bus.if_done | bus.d_done), 64'd0);
            chk("busy_stall", 64'(gd ? bus.stall_mem : bus.stall_if), 64'd1);
            @(posedge clk); #1;
            if (c == lat) break;
        end

        bus.m_ready = 1'($urandom_range(1));
        bus.m_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("done_mreq", 64'(bus.m_req), 64'd0);
        chk("done_if", 64'(bus.if_done), 64'(!gd));
        chk("done_d", 64'(bus.d_done), 64'(gd));
        chk("done_err", 64'(bus.bus_err), 64'(to));
        if (gd) chk("done_drdata", bus.d_rdata, (to || e_we) ? 64'd0 : rd);
        else    chk("done_ifrdata", 64'(bus.if_rdata), to ? 64'd0 : 64'(rd[31:0]));
        chk("done_stall_if", 64'(bus.stall_if), 64'(bus.if_req && gd));
        chk("done_stall_mem", 64'(bus.stall_mem), 64'(bus.d_req && !gd));
        won_d = gd;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
    endtask

    initial begin
        bit w;
        int lat, r;

        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
        bus.m_rdata = '0; bus.m_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outputs", {bus.m_req, bus.m_we, bus.if_done, bus.d_done, bus.bus_err,
                            bus.stall_if, bus.stall_mem}, 64'd0);
        chk("rst_data", bus.m_addr | bus.m_wdata | 64'(bus.m_size) | 64'(bus.if_rdata) | bus.d_rdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single fetch
        bus.if_req = 1; bus.if_addr = 64'h40;
        round(0, 64'hDEADBEEF_91000020, w);
        bus.if_req = 0;
        idle_cycle();

        // Simultaneous store and fetch: data first, then fetch
        bus.if_req = 1; bus.if_addr = 64'h80;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h100; bus.d_wdata = 64'h1234; bus.d_size = 4'd8;
        round(0, 64'h0123_4567_89AB_CDEF, w);
        bus.d_req = 0;
        round(0, 64'h5555_6666_7777_8888, w);
        bus.if_req = 0;

        // Starvation guard: fetch pending under back-to-back loads
        bus.if_req = 1; new_i();
        for (int i = 0; i < 7; i++) begin
            bus.d_req = 1;
            if (i != 5) new_d(1'b0);
            round($urandom_range(2), {$urandom, $urandom}, w);
            if (!w) new_i();
        end
        bus.d_req = 0;
        round(0, {$urandom, $urandom}, w);
        bus.if_req = 0;

        // Slow memory, timeout, and the last-cycle boundary
        bus.d_req = 1; new_d(1'b0);
        round(5, 64'hCAFE_F00D_1234_5678, w);
        new_d(1'b0);
        round(100, 64'hFFFF_FFFF_FFFF_FFFF, w);
        new_d(1'b1);
        round(TIMEOUT - 1, 64'hAAAA_BBBB_CCCC_DDDD, w);
        bus.d_req = 0;
        bus.if_req = 1; new_i();
        round(TIMEOUT, 64'h1111_2222_3333_4444, w);
        bus.if_req = 0;

        // Reset while a load is in flight
        bus.d_req = 1; new_d(1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy_mreq", 64'(bus.m_req), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; bus.m_ready = 1'b1; bus.d_req = 0;
        @(posedge clk); #1;
        reset = 1'b0; bus.m_ready = 1'b0;
        streak = 0;
        @(negedge clk);
        chk("midrst_outputs", {bus.m_req, bus.m_we, bus.if_done, bus.d_done, bus.bus_err}, 64'd0);
        chk("midrst_data", bus.m_addr | bus.m_wdata | 64'(bus.m_size) | bus.d_rdata, 64'd0);
        @(posedge clk); #1;
        idle_cycle();
        bus.d_req = 1; new_d(1'b0);
        round(1, 64'h0BAD_BEEF_0000_0001, w);
        bus.d_req = 0;

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            if (!bus.if_req && $urandom_range(3) != 0) begin bus.if_req = 1; new_i(); end
            if (!bus.d_req && $urandom_range(3) != 0) begin bus.d_req = 1; new_d(1'($urandom_range(1))); end
            if (!bus.if_req && !bus.d_req) begin
                idle_cycle();
            end else begin
                r = $urandom_range(9);
                lat = (r < 7) ? $urandom_range(3) :
                      (r == 7) ? $urandom_range(TIMEOUT - 1, 4) : TIMEOUT + $urandom_range(2);
                round(lat, {$urandom, $urandom}, w);
                if (w) bus.d_req = 0; else bus.if_req = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
